wb_pwm_multi: RTL and testbench
===============================

// Module: wb_pwm_multi
// PURPOSE
//  Parametrised Wishbone (pipelined) PWM generator: CHANNELS outputs, RES-bit duty.
//  Adds programmable period, clock prescaler, per-channel polarity, and shadowed
//  duty/period registers that take effect only at period wrap (glitch-free).
//  Sits on the peripheral Wishbone bus; pwm_o drives pads or downstream logic.
// PARAMETERS
//  CHANNELS  8   number of PWM outputs, 1..16
//  RES       12  counter/duty/period width in bits, 2..16
//  ADDR_W    7   byte-address width of wb_adr_i; map occupies 0x00..0x4F
// PORTS
//  clk_i       in   1         single system clock, rising edge
//  rst_i       in   1         synchronous, active-high reset
//  wb_cyc_i    in   1         bus cycle valid
//  wb_stb_i    in   1         strobe; request accepted when cyc & stb
//  wb_we_i     in   1         1 = write
//  wb_adr_i    in   ADDR_W    byte address, word aligned; bits [1:0] ignored
//  wb_sel_i    in   4         byte enables for writes
//  wb_dat_i    in   32        write data
//  wb_dat_o    out  32        read data, valid when wb_ack_o = 1
//  wb_ack_o    out  1         one ack per accepted request
//  wb_stall_o  out  1         tied 0
//  pwm_o       out  CHANNELS  registered PWM outputs
// BEHAVIOUR
//  Register map (unused bits read 0, writes to them ignored):
//   0x00 CTRL     [0] EN, [1] SYNC_CLR (write-1 pulse, reads 0)
//   0x04 PERIOD   [RES-1:0] shadow top value; counter runs 0..PERIOD
//   0x08 PRESCALE [15:0]; counter advances once every PRESCALE+1 clocks
//   0x0C POLARITY [CHANNELS-1:0]; 1 inverts that channel
//   0x10+4*n DUTY[n] [RES-1:0] shadow duty, n < CHANNELS; others unmapped
//  Bus: request accepted in cycle N -> wb_ack_o=1 and wb_dat_o valid in N+1;
//   back-to-back requests acked every cycle, in order. Unmapped address: ack,
//   read 0, write ignored. wb_sel_i honoured per byte. Reads return shadow values.
//  Reset (rst_i=1 at edge): CTRL, PRESCALE, POLARITY, all DUTY shadow/active = 0;
//   PERIOD shadow/active = 2**RES-1; counter, prescaler = 0; wb_ack_o=0,
//   wb_dat_o=0, pwm_o=0. Reset mid-transfer drops the pending ack.
//  Counter: when EN=1, prescaler counts 0..PRESCALE; on its terminal count
//   cnt increments; at cnt==PERIOD_active it wraps to 0 ("wrap" event).
//  EN=0: cnt and prescaler held at 0; active regs continuously loaded from shadow.
//  Wrap: active PERIOD and all active DUTY load from shadow values as held
//   before any write accepted in the same cycle (that write applies next wrap).
//  SYNC_CLR=1 write: cnt, prescaler -> 0 and actives reload, same edge as write.
//  Compare: raw[n] = (cnt < DUTY_active[n]); pwm_o[n] registered next clock as
//   EN ? raw[n]^POLARITY[n] : POLARITY[n]. POLARITY changes apply immediately.
//  Boundaries: DUTY=0 -> 0 % high; DUTY > PERIOD -> 100 % high; PERIOD=0 ->
//   cnt stays 0, output = (DUTY!=0). Period length = (PERIOD+1)*(PRESCALE+1) clocks;
//   high time = min(DUTY, PERIOD+1)*(PRESCALE+1) clocks. All arithmetic unsigned.
// TESTING
//  1 Reset: pwm_o=0; reads PERIOD=0x0000_0FFF, CTRL/PRESCALE/POLARITY/DUTY0..7 = 0.
//  2 Regs: write 0xFFFF_FFFF to 0x1C -> read 0x0000_0FFF; sel=4'b0001 write 0xAB
//    to PERIOD (0xFFF) -> read 0xFAB; 0x60 write then read -> 0, still acked.
//  3 Duty: EN=1, PERIOD=0xFFF, PRESCALE=0, DUTY0=1024 -> exactly 1024 high
//    clocks per 4096 on pwm_o[0] after first wrap; DUTY7=3000 -> 3000/4096.
//  4 Shadow: DUTY0 1024->3000 written mid-period -> current period 1024 high,
//    next period 3000 high, no extra edges; SYNC_CLR restarts period at once.
//  5 Edges: PERIOD=99, DUTY1=0 -> constant 0; DUTY1=100 -> constant 1; POLARITY=0x02
//    -> pwm_o[1] inverted; EN=0 -> pwm_o = POLARITY.
//  6 Prescale/reset: PRESCALE=3, PERIOD=9, DUTY2=5 -> 40-clock period, 20 high;
//    rst_i pulse mid-period -> pwm_o=0 next clock, regs at reset values.

Source files
------------

// File: rtl/wb_pwm_multi_if.sv
// Pipelined Wishbone slave bundle for wb_pwm_multi; the master drives the
// *_i signals, the slave drives the *_o signals.
interface wb_pwm_multi_if #(
    parameter int unsigned ADDR_W = 7
);
    logic              wb_cyc_i;
    logic              wb_stb_i;
    logic              wb_we_i;
    logic [ADDR_W-1:0] wb_adr_i;
    logic [3:0]        wb_sel_i;
    logic [31:0]       wb_dat_i;
    logic [31:0]       wb_dat_o;
    logic              wb_ack_o;
    logic              wb_stall_o;

    modport slave (
        input  wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_sel_i, wb_dat_i,
        output wb_dat_o, wb_ack_o, wb_stall_o
    );

    modport master (
        output wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_sel_i, wb_dat_i,
        input  wb_dat_o, wb_ack_o, wb_stall_o
    );
endinterface

// File: rtl/wb_pwm_multi.sv
// Multi-channel PWM generator behind a pipelined Wishbone slave. Duty and period
// are shadowed and reach the comparators only at period wrap, SYNC_CLR or while disabled.
module wb_pwm_multi #(
    parameter int unsigned CHANNELS = 8,
    parameter int unsigned RES      = 12,
    parameter int unsigned ADDR_W   = 7
) (
    input  logic                clk_i,
    input  logic                rst_i,
    wb_pwm_multi_if.slave       wb,
    output logic [CHANNELS-1:0] pwm_o
);
    localparam int unsigned WordW = ADDR_W - 2;

    typedef logic [RES-1:0] val_t;

    logic                en_q;
    logic [15:0]         prescale_q;
    logic [CHANNELS-1:0] polarity_q;
    val_t                period_sh_q;
    val_t                period_act_q;
    val_t                duty_sh_q  [CHANNELS];
    val_t                duty_act_q [CHANNELS];
    val_t                cnt_q;
    logic [15:0]         psc_q;
    logic                ack_q;
    logic [31:0]         dat_q;

    logic                req;
    logic                wr;
    logic [WordW-1:0]    word;
    logic [31:0]         wmask;
    logic [31:0]         rdata;
    logic                sync_clr;
    logic                tick;
    logic                wrap;
    logic                reload;
    logic [CHANNELS-1:0] pwm_d;
    logic                unused_adr;

    function automatic logic [31:0] merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                          input logic [31:0] mask);
        return (old_v & ~mask) | (new_v & mask);
    endfunction

    assign req        = wb.wb_cyc_i & wb.wb_stb_i;
    assign wr         = req & wb.wb_we_i;
    assign word       = wb.wb_adr_i[ADDR_W-1:2];
    assign unused_adr = ^wb.wb_adr_i[1:0];

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            wmask[8*i +: 8] = {8{wb.wb_sel_i[i]}};
        end
    end

    always_comb begin
        rdata = '0;
        if (word == WordW'(0)) begin
            rdata[0] = en_q;
        end else if (word == WordW'(1)) begin
            rdata[RES-1:0] = period_sh_q;
        end else if (word == WordW'(2)) begin
            rdata[15:0] = prescale_q;
        end else if (word == WordW'(3)) begin
            rdata[CHANNELS-1:0] = polarity_q;
        end else begin
            for (int n = 0; n < CHANNELS; n++) begin
                if (word == WordW'(4 + n)) begin
                    rdata[RES-1:0] = duty_sh_q[n];
                end
            end
        end
    end

    // Register file: shadow values only; the comparators see the *_act copies.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            en_q        <= 1'b0;
            prescale_q  <= '0;
            polarity_q  <= '0;
            period_sh_q <= '1;
            for (int n = 0; n < CHANNELS; n++) begin
                duty_sh_q[n] <= '0;
            end
        end else if (wr) begin
            if (word == WordW'(0) && wb.wb_sel_i[0]) begin
                en_q <= wb.wb_dat_i[0];
            end
            if (word == WordW'(1)) begin
                period_sh_q <= RES'(merge(32'(period_sh_q), wb.wb_dat_i, wmask));
            end
            if (word == WordW'(2)) begin
                prescale_q <= 16'(merge(32'(prescale_q), wb.wb_dat_i, wmask));
            end
            if (word == WordW'(3)) begin
                polarity_q <= CHANNELS'(merge(32'(polarity_q), wb.wb_dat_i, wmask));
            end
            for (int n = 0; n < CHANNELS; n++) begin
                if (word == WordW'(4 + n)) begin
                    duty_sh_q[n] <= RES'(merge(32'(duty_sh_q[n]), wb.wb_dat_i, wmask));
                end
            end
        end
    end

    assign sync_clr = wr & (word == WordW'(0)) & wb.wb_sel_i[0] & wb.wb_dat_i[1];
    assign tick     = en_q & (psc_q >= prescale_q);
    assign wrap     = tick & (cnt_q >= period_act_q);
    assign reload   = ~en_q | sync_clr | wrap;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
            psc_q <= '0;
        end else if (sync_clr || !en_q) begin
            cnt_q <= '0;
            psc_q <= '0;
        end else if (tick) begin
            psc_q <= '0;
            cnt_q <= wrap ? '0 : cnt_q + 1'b1;
        end else begin
            psc_q <= psc_q + 1'b1;
        end
    end

    // Actives sample the shadows before this cycle's write lands (old value wins).
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            period_act_q <= '1;
            for (int n = 0; n < CHANNELS; n++) begin
                duty_act_q[n] <= '0;
            end
        end else if (reload) begin
            period_act_q <= period_sh_q;
            for (int n = 0; n < CHANNELS; n++) begin
                duty_act_q[n] <= duty_sh_q[n];
            end
        end
    end

    always_comb begin
        pwm_d = polarity_q;
        if (en_q) begin
            for (int n = 0; n < CHANNELS; n++) begin
                pwm_d[n] = (cnt_q < duty_act_q[n]) ^ polarity_q[n];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pwm_o <= '0;
            ack_q <= 1'b0;
            dat_q <= '0;
        end else begin
            pwm_o <= pwm_d;
            ack_q <= req;
            dat_q <= (req && !wb.wb_we_i) ? rdata : '0;
        end
    end

    assign wb.wb_ack_o   = ack_q;
    assign wb.wb_dat_o   = dat_q;
    assign wb.wb_stall_o = 1'b0;
endmodule

// File: tb/tb_wb_pwm_multi.sv
// Bench for wb_pwm_multi: a phase-based model (clocks since period start) checked every
// cycle, plus directed register and duty-window checks with literal expectations.
module tb_wb_pwm_multi;
    localparam int unsigned CH = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [CH-1:0] pwm;
    int            checks = 0;
    int            errors = 0;
    logic          chk_on = 1'b0;

    wb_pwm_multi_if #(.ADDR_W(7)) wb ();

    wb_pwm_multi #(.CHANNELS(CH), .RES(12), .ADDR_W(7)) u_dut (
        .clk_i (clk),
        .rst_i (rst),
        .wb    (wb),
        .pwm_o (pwm)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: registers as seen from the bus, output from phase within the current period.
    logic          m_en;
    logic [15:0]   m_pre;
    logic [CH-1:0] m_pol;
    logic [11:0]   m_per_sh, m_per_act;
    logic [11:0]   m_duty_sh [CH];
    logic [11:0]   m_duty_act [CH];
    int unsigned   m_t;
    logic [CH-1:0] m_pwm;
    logic          m_ack, m_rd;
    logic [31:0]   m_dat;

    function automatic logic [31:0] bmerge(input logic [31:0] o, input logic [31:0] d,
                                           input logic [3:0] s);
        logic [31:0] r;
        r = o;
        for (int i = 0; i < 4; i++) if (s[i]) r[8*i +: 8] = d[8*i +: 8];
        return r;
    endfunction

    function automatic logic [31:0] m_read(input int unsigned w);
        if (w == 0) return {31'b0, m_en};
        if (w == 1) return {20'b0, m_per_sh};
        if (w == 2) return {16'b0, m_pre};
        if (w == 3) return {24'b0, m_pol};
        if (w >= 4 && w < 4 + CH) return {20'b0, m_duty_sh[w-4]};
        return 32'h0;
    endfunction

    always @(posedge clk) begin : model
        logic          req, we, clr;
        int unsigned   w, cnt, per_len, pre;
        logic [31:0]   d, mv;
        logic [3:0]    s;
        logic [CH-1:0] nxt;
        req = wb.wb_cyc_i & wb.wb_stb_i;
        we  = wb.wb_we_i;
        w   = 32'(wb.wb_adr_i[6:2]);
        d   = wb.wb_dat_i;
        s   = wb.wb_sel_i;
        if (rst) begin
            m_en <= 1'b0; m_pre <= '0; m_pol <= '0;
            m_per_sh <= 12'hFFF; m_per_act <= 12'hFFF;
            for (int n = 0; n < CH; n++) begin
                m_duty_sh[n] <= '0; m_duty_act[n] <= '0;
            end
            m_t <= 0; m_pwm <= '0; m_ack <= 1'b0; m_rd <= 1'b0; m_dat <= '0;
        end else begin
            pre     = 32'(m_pre) + 1;
            per_len = (32'(m_per_act) + 1) * pre;
            cnt     = m_t / pre;
            for (int n = 0; n < CH; n++)
                nxt[n] = m_en ? ((cnt < 32'(m_duty_act[n])) ^ m_pol[n]) : m_pol[n];
            m_pwm <= nxt;
            m_ack <= req;
            m_rd  <= req & !we;
            m_dat <= m_read(w);
            clr = req && we && w == 0 && s[0] && d[1];
            if (!m_en || clr || m_t + 1 == per_len) begin
                m_t <= 0;
                m_per_act <= m_per_sh;
                for (int n = 0; n < CH; n++) m_duty_act[n] <= m_duty_sh[n];
            end else begin
                m_t <= m_t + 1;
            end
            if (req && we) begin
                mv = bmerge(m_read(w), d, s);
                if (w == 0 && s[0]) m_en <= d[0];
                if (w == 1) m_per_sh <= mv[11:0];
                if (w == 2) m_pre <= mv[15:0];
                if (w == 3) m_pol <= mv[CH-1:0];
                if (w >= 4 && w < 4 + CH) m_duty_sh[w-4] <= mv[11:0];
            end
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            check("pwm_vs_model", 32'(pwm), 32'(m_pwm));
            check("ack_vs_model", 32'(wb.wb_ack_o), 32'(m_ack));
            if (m_ack && m_rd) check("rdata_vs_model", wb.wb_dat_o, m_dat);
        end
    end

    // Window measurement of high clocks and rising edges on one channel.
    int            meas_ch = 0;
    int            meas_left = 0;
    int            meas_len = 0;
    logic          arm = 1'b0;
    int            hi = 0;
    int            rises = 0;
    logic [CH-1:0] prev = '0;

    always @(negedge clk) begin
        if (meas_left > 0) begin
            hi        <= hi + 32'(pwm[meas_ch]);
            rises     <= rises + 32'(pwm[meas_ch] && !prev[meas_ch]);
            meas_left <= meas_left - 1;
        end else if (arm && pwm[meas_ch] && !prev[meas_ch]) begin
            arm       <= 1'b0;
            hi        <= 1;
            rises     <= 1;
            meas_left <= meas_len - 1;
        end
        prev <= pwm;
    end

    task automatic bus(input logic we, input logic [6:0] adr, input logic [31:0] d,
                       input logic [3:0] s, output logic [31:0] q, output logic a);
        @(posedge clk); #1;
        wb.wb_cyc_i = 1'b1; wb.wb_stb_i = 1'b1; wb.wb_we_i = we;
        wb.wb_adr_i = adr; wb.wb_dat_i = d; wb.wb_sel_i = s;
        @(posedge clk); #1;
        wb.wb_cyc_i = 1'b0; wb.wb_stb_i = 1'b0; wb.wb_we_i = 1'b0;
        q = wb.wb_dat_o;
        a = wb.wb_ack_o;
    endtask

    task automatic wr(input logic [6:0] adr, input logic [31:0] d, input logic [3:0] s = 4'hF);
        logic [31:0] q;
        logic        a;
        bus(1'b1, adr, d, s, q, a);
    endtask

    task automatic rd_chk(input string name, input logic [6:0] adr, input logic [31:0] exp);
        logic [31:0] q;
        logic        a;
        bus(1'b0, adr, 32'h0, 4'hF, q, a);
        check(name, q, exp);
        check({name, "_ack"}, 32'(a), 32'h1);
    endtask

    task automatic wait_meas(input string name, input int budget);
        int n = 0;
        while ((meas_left != 0 || arm) && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        if (meas_left != 0 || arm) begin
            check({name, "_timeout"}, 32'h1, 32'h0);
            meas_left = 0;
            arm = 1'b0;
        end
    endtask

    task automatic start_win(input int ch, input int len, input logic armed);
        meas_ch = ch; hi = 0; rises = 0;
        if (armed) begin meas_len = len; arm = 1'b1; end
        else meas_left = len;
    endtask

    initial begin
        logic [31:0] q1, q2, q3;
        logic        a1, a2, a3;
        wb.wb_cyc_i = 1'b0; wb.wb_stb_i = 1'b0; wb.wb_we_i = 1'b0;
        wb.wb_adr_i = '0; wb.wb_dat_i = '0; wb.wb_sel_i = '0;
        @(posedge clk); #1;
        chk_on = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        check("rst_pwm", 32'(pwm), 32'h0);
        check("rst_ack", 32'(wb.wb_ack_o), 32'h0);
        check("rst_dat", wb.wb_dat_o, 32'h0);
        check("stall", 32'(wb.wb_stall_o), 32'h0);
        rd_chk("rst_period", 7'h04, 32'h0000_0FFF);
        rd_chk("rst_ctrl", 7'h00, 32'h0);
        rd_chk("rst_prescale", 7'h08, 32'h0);
        rd_chk("rst_polarity", 7'h0C, 32'h0);
        for (int n = 0; n < CH; n++) rd_chk($sformatf("rst_duty%0d", n), 7'(16 + 4 * n), 32'h0);

        // Register widths, byte enables, unmapped space, back-to-back requests
        wr(7'h1C, 32'hFFFF_FFFF);
        rd_chk("duty3_mask", 7'h1C, 32'h0000_0FFF);
        wr(7'h04, 32'h0000_00AB, 4'b0001);
        rd_chk("period_sel0", 7'h04, 32'h0000_0FAB);
        wr(7'h60, 32'h1234_5678);
        rd_chk("unmapped", 7'h60, 32'h0);
        @(posedge clk); #1;
        wb.wb_cyc_i = 1'b1; wb.wb_stb_i = 1'b1; wb.wb_we_i = 1'b1;
        wb.wb_adr_i = 7'h04; wb.wb_dat_i = 32'h123; wb.wb_sel_i = 4'hF;
        @(posedge clk); #1;
        a1 = wb.wb_ack_o;
        wb.wb_we_i = 1'b0; wb.wb_adr_i = 7'h04;
        @(posedge clk); #1;
        a2 = wb.wb_ack_o; q2 = wb.wb_dat_o;
        wb.wb_adr_i = 7'h60;
        @(posedge clk); #1;
        a3 = wb.wb_ack_o; q3 = wb.wb_dat_o;
        wb.wb_cyc_i = 1'b0; wb.wb_stb_i = 1'b0;
        q1 = {29'b0, a1, a2, a3};
        check("b2b_acks", q1, 32'h7);
        check("b2b_read", q2, 32'h123);
        check("b2b_unmapped", q3, 32'h0);

        // Duty ratio over full 4096-clock periods
        wr(7'h04, 32'hFFF);
        wr(7'h08, 32'h0);
        wr(7'h10, 32'd1024);
        wr(7'h2C, 32'd3000);
        wr(7'h00, 32'h1);
        start_win(0, 4096, 1'b1);
        wait_meas("duty0_win", 9000);
        check("duty0_high", 32'(hi), 32'd1024);
        check("duty0_rises", 32'(rises), 32'd1);
        start_win(7, 4096, 1'b1);
        wait_meas("duty7_win", 9000);
        check("duty7_high", 32'(hi), 32'd3000);

        // Shadowed duty change mid-period, then SYNC_CLR restart
        start_win(0, 4096, 1'b1);
        begin
            int n = 0;
            while (arm && n < 9000) begin @(posedge clk); #1; n++; end
        end
        repeat (2000) @(posedge clk);
        #1 wr(7'h10, 32'd3000);
        wait_meas("shadow_cur", 9000);
        check("shadow_cur_high", 32'(hi), 32'd1024);
        check("shadow_cur_rises", 32'(rises), 32'd1);
        start_win(0, 4096, 1'b1);
        wait_meas("shadow_next", 9000);
        check("shadow_next_high", 32'(hi), 32'd3000);
        check("shadow_next_rises", 32'(rises), 32'd1);
        repeat (3500) @(posedge clk);
        #1 wr(7'h00, 32'h3);
        @(posedge clk); #1;
        start_win(0, 3000, 1'b0);
        wait_meas("sync_clr", 4000);
        check("sync_clr_high", 32'(hi), 32'd3000);
        check("sync_clr_rises", 32'(rises), 32'd1);
        rd_chk("ctrl_readback", 7'h00, 32'h1);

        // Boundaries: duty 0, duty > period, polarity, disabled output
        wr(7'h00, 32'h0);
        wr(7'h04, 32'd99);
        wr(7'h14, 32'd0);
        wr(7'h00, 32'h1);
        repeat (3) @(posedge clk);
        #1 start_win(1, 100, 1'b0);
        wait_meas("duty_zero", 300);
        check("duty_zero_high", 32'(hi), 32'd0);
        wr(7'h14, 32'd100);
        repeat (110) @(posedge clk);
        #1 start_win(1, 100, 1'b0);
        wait_meas("duty_full", 300);
        check("duty_full_high", 32'(hi), 32'd100);
        wr(7'h0C, 32'h02);
        @(posedge clk); #1;
        start_win(1, 100, 1'b0);
        wait_meas("pol_inv", 300);
        check("pol_inv_high", 32'(hi), 32'd0);
        wr(7'h00, 32'h0);
        @(posedge clk); #1;
        check("en0_pwm_is_pol", 32'(pwm), 32'h02);

        // Prescaler, then reset mid-period with a request in flight
        wr(7'h0C, 32'h0);
        wr(7'h08, 32'd3);
        wr(7'h04, 32'd9);
        wr(7'h18, 32'd5);
        wr(7'h00, 32'h1);
        start_win(2, 40, 1'b1);
        wait_meas("prescale", 200);
        check("prescale_high", 32'(hi), 32'd20);
        check("prescale_rises", 32'(rises), 32'd1);
        repeat (13) @(posedge clk);
        #1;
        rst = 1'b1;
        wb.wb_cyc_i = 1'b1; wb.wb_stb_i = 1'b1; wb.wb_we_i = 1'b0; wb.wb_adr_i = 7'h04;
        @(posedge clk); #1;
        rst = 1'b0;
        wb.wb_cyc_i = 1'b0; wb.wb_stb_i = 1'b0;
        check("midrst_pwm", 32'(pwm), 32'h0);
        check("midrst_ack", 32'(wb.wb_ack_o), 32'h0);
        rd_chk("midrst_period", 7'h04, 32'h0000_0FFF);
        rd_chk("midrst_prescale", 7'h08, 32'h0);
        rd_chk("midrst_duty2", 7'h18, 32'h0);
        rd_chk("midrst_ctrl", 7'h00, 32'h0);
        repeat (5) @(posedge clk);
        #1 chk_on = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
